// File: rtl/lfsr6_pkg.sv
// lfsr6_pkg: shared LFSR width, guard seed, step function and decryptor state encoding
package lfsr6_pkg;

    localparam int LFSR_W = 6;
    localparam logic [LFSR_W-1:0] GUARD_SEED = 6'b000001;

    typedef enum logic [1:0] {UNSEEDED, RUN, FULL} dec_state_t;

    // x^6+x+1 Fibonacci step, bit-exact with the transmitter
    function automatic logic [LFSR_W-1:0] lfsr6_next(input logic [LFSR_W-1:0] s);
        return {s[0] ^ s[1], s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/lfsr6_core.sv
// lfsr6_core: keystream state register with seed capture, per-word step and reload of the stored seed
module lfsr6_core
    import lfsr6_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    input  logic              reload,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] seed_reg;

    // load beats reload beats step; seed_reg remembers the seed for rekeying
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= '0;
            seed_reg <= '0;
        end else if (load) begin
            state    <= seed;
            seed_reg <= seed;
        end else if (reload) begin
            state    <= seed_reg;
        end else if (step) begin
            state    <= lfsr6_next(state);
        end
    end

endmodule

// File: rtl/stream_decrypt_6.sv
// stream_decrypt_6: LFSR stream-cipher receiver with valid/ready handshakes and a 1-word output register
// Optional build macro: ZERO_SEED_GUARD_EN (replace a zero seed with GUARD_SEED and pulse seed_err)
module stream_decrypt_6
    import lfsr6_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int REKEY_LEN = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              ct_valid,
    output logic              ct_ready,
    input  logic [LFSR_W-1:0] ct_data,
    output logic              pt_valid,
    input  logic              pt_ready,
    output logic [LFSR_W-1:0] pt_data,
    output logic              seeded,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              seed_err
);

    dec_state_t        state, state_nx;
    logic              accept;
    logic              rekey;
    logic [CNT_W-1:0]  cnt_inc;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] seed_eff;

`ifdef ZERO_SEED_GUARD_EN
    assign seed_eff = (seed_in == '0) ? GUARD_SEED : seed_in;

    // flag a zero seed for one cycle after it is loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seed_err <= 1'b0;
        else        seed_err <= seed_load && (seed_in == '0);
    end
`else
    assign seed_eff = seed_in;
    assign seed_err = 1'b0;
`endif

    assign cnt_inc = word_cnt + 1'b1;
    assign rekey   = (REKEY_LEN != 0) && accept && (cnt_inc == CNT_W'(REKEY_LEN));

    lfsr6_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (seed_load),
        .seed   (seed_eff),
        .step   (accept && !rekey),
        .reload (rekey),
        .state  (lfsr)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= UNSEEDED;
        else        state <= state_nx;
    end

    // handshake and next state; seed_load overrides everything
    always_comb begin
        ct_ready = (state != UNSEEDED) && !seed_load && (!pt_valid || pt_ready);
        accept   = ct_valid && ct_ready;
        state_nx = state;
        if (seed_load)                                 state_nx = RUN;
        else if (state == RUN && accept && !pt_ready)  state_nx = FULL;
        else if (state == FULL && pt_ready && !accept) state_nx = RUN;
    end

    // output register, word counter and seeded flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pt_valid <= 1'b0;
            pt_data  <= '0;
            word_cnt <= '0;
            seeded   <= 1'b0;
        end else if (seed_load) begin
            pt_valid <= 1'b0;
            word_cnt <= '0;
            seeded   <= 1'b1;
        end else if (accept) begin
            pt_valid <= 1'b1;
            pt_data  <= ct_data ^ lfsr;
            word_cnt <= rekey ? '0 : cnt_inc;
        end else if (pt_ready) begin
            pt_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_decrypt_6.sv
// tb_stream_decrypt_6: directed vector table plus hand sequences for reseed, rekey and async reset
module tb_stream_decrypt_6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       seed_load;
    logic [5:0] seed_in;
    logic       ct_valid;
    logic [5:0] ct_data;
    logic       pt_ready;
    logic       ct_ready, pt_valid, seeded, seed_err;
    logic [5:0] pt_data;
    logic [7:0] word_cnt;
    logic       r_ct_ready, r_pt_valid, r_seeded, r_seed_err;
    logic [5:0] r_pt_data;
    logic [7:0] r_word_cnt;

    int tests = 0;
    int fails = 0;

`ifdef ZERO_SEED_GUARD_EN
    localparam logic       EXP_ERR  = 1'b1;
    localparam logic [5:0] EXP_ZERO = 6'b000001;
`else
    localparam logic       EXP_ERR  = 1'b0;
    localparam logic [5:0] EXP_ZERO = 6'b000000;
`endif

    always #5 clk = ~clk;

    stream_decrypt_6 #(.CNT_W(8), .REKEY_LEN(0)) dut (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
        .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
        .seeded(seeded), .word_cnt(word_cnt), .seed_err(seed_err)
    );

    stream_decrypt_6 #(.CNT_W(8), .REKEY_LEN(3)) dut_r (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
        .ct_valid(ct_valid), .ct_ready(r_ct_ready), .ct_data(ct_data),
        .pt_valid(r_pt_valid), .pt_ready(pt_ready), .pt_data(r_pt_data),
        .seeded(r_seeded), .word_cnt(r_word_cnt), .seed_err(r_seed_err)
    );

    typedef struct {
        logic       ld;
        logic [5:0] sd;
        logic       cv;
        logic [5:0] cd;
        logic       pr;
        logic       e_ctr;
        logic       e_pv;
        logic [5:0] e_pd;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input logic ld, input logic [5:0] sd, input logic cv,
                                input logic [5:0] cd, input logic pr, input logic e_ctr,
                                input logic e_pv, input logic [5:0] e_pd, input logic [7:0] e_cnt);
        vec_t v;
        v.ld = ld; v.sd = sd; v.cv = cv; v.cd = cd; v.pr = pr;
        v.e_ctr = e_ctr; v.e_pv = e_pv; v.e_pd = e_pd; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // drive one cycle: ct_ready checked mid-cycle, registered outputs 1 time unit after the edge
    task automatic cyc(input vec_t v, input string nm);
        seed_load = v.ld; seed_in = v.sd; ct_valid = v.cv; ct_data = v.cd; pt_ready = v.pr;
        @(negedge clk);
        chk({nm, ".ct_ready"}, ct_ready, v.e_ctr);
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        chk({nm, ".pt_valid"}, pt_valid, v.e_pv);
        chk({nm, ".pt_data"}, pt_data, v.e_pd);
        chk({nm, ".word_cnt"}, word_cnt, v.e_cnt);
    endtask

    initial begin
        // T1: three zero words reveal the keystream
        tbl[0]  = mk(1, 6'b101101, 0, 6'b000000, 1, 0, 0, 6'b000000, 0);
        tbl[1]  = mk(0, 6'b000000, 1, 6'b000000, 1, 1, 1, 6'b101101, 1);
        tbl[2]  = mk(0, 6'b000000, 1, 6'b000000, 1, 1, 1, 6'b110110, 2);
        tbl[3]  = mk(0, 6'b000000, 1, 6'b000000, 1, 1, 1, 6'b111011, 3);
        // T2: reseed then ct 111111
        tbl[4]  = mk(1, 6'b101101, 1, 6'b000000, 1, 0, 0, 6'b111011, 0);
        tbl[5]  = mk(0, 6'b000000, 1, 6'b111111, 1, 1, 1, 6'b010010, 1);
        tbl[6]  = mk(0, 6'b000000, 0, 6'b000000, 1, 1, 0, 6'b010010, 1);
        // T3: backpressure for 4 cycles, then release
        tbl[7]  = mk(1, 6'b101101, 0, 6'b000000, 0, 0, 0, 6'b010010, 0);
        tbl[8]  = mk(0, 6'b000000, 1, 6'b000000, 0, 1, 1, 6'b101101, 1);
        tbl[9]  = mk(0, 6'b000000, 1, 6'b000000, 0, 0, 1, 6'b101101, 1);
        tbl[10] = mk(0, 6'b000000, 1, 6'b000000, 0, 0, 1, 6'b101101, 1);
        tbl[11] = mk(0, 6'b000000, 1, 6'b000000, 0, 0, 1, 6'b101101, 1);
        tbl[12] = mk(0, 6'b000000, 1, 6'b000000, 1, 1, 1, 6'b110110, 2);
        tbl[13] = mk(0, 6'b000000, 0, 6'b000000, 1, 1, 0, 6'b110110, 2);
        // T4: seed_load while FULL drops the pending word
        tbl[14] = mk(0, 6'b000000, 1, 6'b000000, 0, 1, 1, 6'b111011, 3);
        tbl[15] = mk(1, 6'b000111, 1, 6'b000000, 0, 0, 0, 6'b111011, 0);
        tbl[16] = mk(0, 6'b000000, 1, 6'b000000, 1, 1, 1, 6'b000111, 1);

        rst_n = 1'b0; seed_load = 1'b0; seed_in = '0; ct_valid = 1'b0; ct_data = '0; pt_ready = 1'b0;
        #12;
        chk("reset.pt_valid", pt_valid, 0);
        chk("reset.pt_data", pt_data, 0);
        chk("reset.word_cnt", word_cnt, 0);
        chk("reset.seeded", seeded, 0);
        chk("reset.seed_err", seed_err, 0);
        chk("reset.ct_ready", ct_ready, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ct_valid = 1'b1;
        pt_ready = 1'b1;
        #2;
        chk("unseeded.ct_ready", ct_ready, 0);

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i], $sformatf("vec%0d", i));
            if (i == 0) chk("vec0.seeded", seeded, 1);
        end

        // T5: rekey after 3 words on dut_r, free-running on dut
        cyc(mk(1, 6'b101101, 0, 6'b000000, 1, 0, 0, 6'b000111, 0), "t5.load");
        cyc(mk(0, 6'b000000, 1, 6'b000000, 1, 1, 1, 6'b101101, 1), "t5.w1");
        chk("t5.w1.r_pt_data", r_pt_data, 6'b101101);
        chk("t5.w1.r_word_cnt", r_word_cnt, 1);
        cyc(mk(0, 6'b000000, 1, 6'b000000, 1, 1, 1, 6'b110110, 2), "t5.w2");
        chk("t5.w2.r_pt_data", r_pt_data, 6'b110110);
        chk("t5.w2.r_word_cnt", r_word_cnt, 2);
        cyc(mk(0, 6'b000000, 1, 6'b000000, 1, 1, 1, 6'b111011, 3), "t5.w3");
        chk("t5.w3.r_pt_data", r_pt_data, 6'b111011);
        chk("t5.w3.r_word_cnt", r_word_cnt, 0);
        cyc(mk(0, 6'b000000, 1, 6'b000000, 1, 1, 1, 6'b011101, 4), "t5.w4");
        chk("t5.w4.r_pt_data", r_pt_data, 6'b101101);
        chk("t5.w4.r_word_cnt", r_word_cnt, 1);
        chk("t5.w4.r_pt_valid", r_pt_valid, 1);

        // T6: async reset mid-stream, then a zero seed
        ct_valid = 1'b1; ct_data = '0; pt_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.pt_valid", pt_valid, 0);
        chk("t6.pt_data", pt_data, 0);
        chk("t6.word_cnt", word_cnt, 0);
        chk("t6.seeded", seeded, 0);
        chk("t6.ct_ready", ct_ready, 0);
        chk("t6.r_pt_valid", r_pt_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(mk(0, 6'b000000, 1, 6'b000000, 1, 0, 0, 6'b000000, 0), "t6.idle");
        cyc(mk(1, 6'b000000, 1, 6'b000000, 1, 0, 0, 6'b000000, 0), "t6.zload");
        chk("t6.zload.seed_err", seed_err, EXP_ERR);
        chk("t6.zload.seeded", seeded, 1);
        cyc(mk(0, 6'b000000, 1, 6'b000000, 1, 1, 1, EXP_ZERO, 1), "t6.zword");
        chk("t6.zword.seed_err", seed_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
